score_keeper: RTL

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/pong_pkg.sv | 13 +
 rtl/rise_detect.sv | 34 +++
 rtl/score_keeper.sv | 97 +++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong score keeper: FSM encoding and default game limits.
package pong_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_SERVE = 2'd0;
   localparam state_t ST_PLAY  = 2'd1;
   localparam state_t ST_OVER  = 2'd2;

   localparam logic [3:0]  DEFAULT_WIN_SCORE = 4'd9;
   localparam logic [15:0] DEFAULT_PAUSE_MS  = 16'd1000;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector with registered history; SCORE_KEEPER_SYNC_EN adds a
// two-flop synchronizer in front of the detector.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic sig_s;
   logic prev_q;

`ifdef SCORE_KEEPER_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], sig};
   end

   assign sig_s = sync_q[1];
`else
   assign sig_s = sig;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) prev_q <= 1'b0;
      else        prev_q <= sig_s;
   end

   // Combinational against the stored history so the FSM acts on the detecting edge.
   assign rise = sig_s & ~prev_q;

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: serve pause, goal scoring, win detection and restart.
// Optional macro SCORE_KEEPER_SYNC_EN synchronizes goal_p1/goal_p2/clk_1ms.
//
// state    | meaning
// ST_SERVE | ball held at centre, counting clk_1ms ticks up to PAUSE_MS
// ST_PLAY  | rally in progress, first goal event scores
// ST_OVER  | a player reached WIN_SCORE, waiting for new_game
module score_keeper
   import pong_pkg::*;
#(
   parameter logic [3:0]  WIN_SCORE = DEFAULT_WIN_SCORE,
   parameter logic [15:0] PAUSE_MS  = DEFAULT_PAUSE_MS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk_1ms,
   input  logic       goal_p1,
   input  logic       goal_p2,
   input  logic       new_game,
   output logic [3:0] p1_score,
   output logic [3:0] p2_score,
   output logic       ball_hold,
   output logic       serve_dir,
   output logic       goal_flash
);

   state_t      state_q;
   logic [15:0] cnt_q;
   logic        tick;
   logic        g1_rise;
   logic        g2_rise;

   rise_detect u_tick (.clk(clk), .reset(reset), .sig(clk_1ms), .rise(tick));
   rise_detect u_g1   (.clk(clk), .reset(reset), .sig(goal_p1), .rise(g1_rise));
   rise_detect u_g2   (.clk(clk), .reset(reset), .sig(goal_p2), .rise(g2_rise));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_SERVE;
         cnt_q      <= 16'd0;
         p1_score   <= 4'd0;
         p2_score   <= 4'd0;
         ball_hold  <= 1'b1;
         serve_dir  <= 1'b0;
         goal_flash <= 1'b0;
      end else begin
         goal_flash <= 1'b0;
         case (state_q)
            ST_SERVE: begin
               ball_hold <= 1'b1;
               if (tick) begin
                  if (cnt_q + 16'd1 == PAUSE_MS) begin
                     cnt_q     <= 16'd0;
                     ball_hold <= 1'b0;
                     state_q   <= ST_PLAY;
                  end else begin
                     cnt_q <= cnt_q + 16'd1;
                  end
               end
            end
            ST_PLAY: begin
               // Player 1 wins a same-edge tie; the player-2 event is dropped.
               if (g1_rise) begin
                  p1_score   <= p1_score + 4'd1;
                  serve_dir  <= 1'b1;
                  goal_flash <= 1'b1;
                  ball_hold  <= 1'b1;
                  cnt_q      <= 16'd0;
                  state_q    <= (p1_score + 4'd1 == WIN_SCORE) ? ST_OVER : ST_SERVE;
               end else if (g2_rise) begin
                  p2_score   <= p2_score + 4'd1;
                  serve_dir  <= 1'b0;
                  goal_flash <= 1'b1;
                  ball_hold  <= 1'b1;
                  cnt_q      <= 16'd0;
                  state_q    <= (p2_score + 4'd1 == WIN_SCORE) ? ST_OVER : ST_SERVE;
               end
            end
            ST_OVER: begin
               ball_hold <= 1'b1;
               if (new_game) begin
                  p1_score <= 4'd0;
                  p2_score <= 4'd0;
                  cnt_q    <= 16'd0;
                  state_q  <= ST_SERVE;
               end
            end
            default: begin
               state_q   <= ST_SERVE;
               cnt_q     <= 16'd0;
               ball_hold <= 1'b1;
            end
         endcase
      end
   end

endmodule
